// File: rtl/ref_buffer_pkg.sv
// Shared definitions for the circular I/Q reference buffer: state encoding,
// default widths and the index-wrap helper.
package ref_buffer_pkg;

    localparam int DEF_I_BITS     = 12;
    localparam int DEF_Q_BITS     = 12;
    localparam int DEF_BUF_LENGTH = 64;
    localparam int DEF_INDEX_BITS = 6;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Single-step wrap: an index at or beyond len has len subtracted once.
    function automatic int unsigned wrap_index(input int unsigned idx, input int unsigned len);
        if (idx >= len) begin
            return idx - len;
        end else begin
            return idx;
        end
    endfunction

endpackage

// File: rtl/ref_skid_buffer.sv
// Two-entry valid/ready output register. Entry 0 drives the outputs directly,
// entry 1 absorbs the sample still in flight when the consumer stalls.
module ref_skid_buffer #(
    parameter int DW = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    level
);

    logic          valid0_r;
    logic          valid1_r;
    logic [DW-1:0] data0_r;
    logic [DW-1:0] data1_r;
    logic          push_s;
    logic          pop_s;

    assign push_s    = in_valid;
    assign pop_s     = valid0_r & out_ready;
    assign out_valid = valid0_r;
    assign out_data  = data0_r;
    assign level     = {valid1_r, valid0_r & ~valid1_r};

    // Entry storage and shifting; the upstream never pushes into a full buffer without a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_r <= 1'b0;
            valid1_r <= 1'b0;
            data0_r  <= {DW{1'b0}};
            data1_r  <= {DW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (!valid0_r) begin
                        data0_r  <= in_data;
                        valid0_r <= 1'b1;
                    end else if (!valid1_r) begin
                        data1_r  <= in_data;
                        valid1_r <= 1'b1;
                    end
                end
                2'b01: begin
                    if (valid1_r) begin
                        data0_r  <= data1_r;
                        valid1_r <= 1'b0;
                    end else begin
                        valid0_r <= 1'b0;
                    end
                end
                2'b11: begin
                    if (valid1_r) begin
                        data0_r <= data1_r;
                        data1_r <= in_data;
                    end else begin
                        data0_r <= in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ref_circular_buffer.sv
// Circular I/Q reference-sample store: valid/ready loading, burst reads of
// rlen+1 samples from any start index with wrap at BUF_LENGTH.
module ref_circular_buffer
    import ref_buffer_pkg::*;
#(
    parameter int I_BITS     = DEF_I_BITS,
    parameter int Q_BITS     = DEF_Q_BITS,
    parameter int BUF_LENGTH = DEF_BUF_LENGTH,
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_axi_wr_valid,
    output logic                         s_axi_wr_ready,
    input  logic signed [I_BITS-1:0]     wr_i,
    input  logic signed [Q_BITS-1:0]     wr_q,
    input  logic                         wr_last,
    input  logic                         m_axi_ref_rvalid,
    output logic                         s_axi_ref_arready,
    input  logic [INDEX_BITS-1:0]        m_axi_ref_raddr,
    input  logic [INDEX_BITS-1:0]        m_axi_ref_rlen,
    input  logic                         m_axi_ref_rready,
    output logic                         s_axi_ref_rvalid,
    output logic signed [I_BITS-1:0]     ref_i,
    output logic signed [Q_BITS-1:0]     ref_q,
    output logic                         s_axi_ref_rlast,
    output logic                         loaded
);

    localparam int AW = (BUF_LENGTH > 1) ? $clog2(BUF_LENGTH) : 1;
    localparam int DW = I_BITS + Q_BITS;

    state_e                state_r;
    state_e                state_nxt_s;
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [INDEX_BITS-1:0] remaining_r;
    logic                  issue_active_r;
    logic [DW-1:0]         mem_r [BUF_LENGTH];
    logic [DW:0]           mem_data_r;
    logic                  mem_valid_r;
    logic                  wr_ready_r;
    logic                  arready_r;
    logic                  loaded_r;

    logic                  wr_fire_s;
    logic                  rd_fire_s;
    logic                  pop_s;
    logic                  issue_s;
    logic                  wr_wrap_s;
    logic                  loaded_nxt_s;
    logic                  last_issue_s;
    logic [1:0]            level_s;
    logic [1:0]            occ_s;
    logic                  out_valid_s;
    logic [DW:0]           out_data_s;

    assign wr_fire_s    = s_axi_wr_valid & wr_ready_r;
    assign rd_fire_s    = m_axi_ref_rvalid & arready_r;
    assign pop_s        = out_valid_s & m_axi_ref_rready;
    assign wr_wrap_s    = (wr_ptr_r == AW'(BUF_LENGTH - 1)) | wr_last;
    assign loaded_nxt_s = loaded_r | (wr_fire_s & wr_wrap_s);
    assign last_issue_s = (remaining_r == {INDEX_BITS{1'b0}});

    // Samples in the memory stage plus the skid must never exceed the skid depth.
    assign occ_s   = level_s + {1'b0, mem_valid_r};
    assign issue_s = issue_active_r & ((occ_s < 2'd2) | (pop_s & (occ_s == 2'd2)));

    assign s_axi_wr_ready    = wr_ready_r;
    assign s_axi_ref_arready = arready_r;
    assign loaded            = loaded_r;
    assign s_axi_ref_rvalid  = out_valid_s;
    assign ref_i             = out_data_s[DW -: I_BITS];
    assign ref_q             = out_data_s[Q_BITS:1];
    assign s_axi_ref_rlast   = out_data_s[0];

    // Next-state decode for the request/burst FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_fire_s) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (pop_s & out_data_s[0]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, registered handshake outputs, load flag and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wr_ready_r <= 1'b0;
            arready_r  <= 1'b0;
            loaded_r   <= 1'b0;
            wr_ptr_r   <= {AW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wr_ready_r <= (state_nxt_s == ST_IDLE);
            arready_r  <= loaded_nxt_s & (state_nxt_s == ST_IDLE);
            loaded_r   <= loaded_nxt_s;
            if (wr_fire_s) begin
                if (wr_wrap_s) begin
                    wr_ptr_r <= {AW{1'b0}};
                end else begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
            end
        end
    end

    // Sample storage; contents survive reset, the loaded flag gates reuse.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_ptr_r] <= {wr_i, wr_q};
        end
    end

    // Read address/counter and the registered memory stage feeding the skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r       <= {AW{1'b0}};
            remaining_r    <= {INDEX_BITS{1'b0}};
            issue_active_r <= 1'b0;
            mem_valid_r    <= 1'b0;
            mem_data_r     <= {(DW + 1){1'b0}};
        end else begin
            mem_valid_r <= issue_s;
            if (rd_fire_s) begin
                rd_ptr_r       <= AW'(wrap_index(32'(m_axi_ref_raddr), BUF_LENGTH));
                remaining_r    <= m_axi_ref_rlen;
                issue_active_r <= 1'b1;
            end else if (issue_s) begin
                mem_data_r <= {mem_r[rd_ptr_r], last_issue_s};
                if (rd_ptr_r == AW'(BUF_LENGTH - 1)) begin
                    rd_ptr_r <= {AW{1'b0}};
                end else begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                if (last_issue_s) begin
                    issue_active_r <= 1'b0;
                end else begin
                    remaining_r <= remaining_r - INDEX_BITS'(1);
                end
            end
        end
    end

    ref_skid_buffer #(
        .DW (DW + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (mem_valid_r),
        .in_data   (mem_data_r),
        .out_ready (m_axi_ref_rready),
        .out_valid (out_valid_s),
        .out_data  (out_data_s),
        .level     (level_s)
    );

endmodule

// File: tb/tb_ref_circular_buffer.sv
// Directed bench for ref_circular_buffer (BUF_LENGTH=8): a scoreboard queue of
// expected samples is filled at request time and drained by an output monitor.
module tb_ref_circular_buffer;

    logic               clk;
    logic               rst_n;
    logic               s_axi_wr_valid;
    logic               s_axi_wr_ready;
    logic signed [11:0] wr_i;
    logic signed [11:0] wr_q;
    logic               wr_last;
    logic               m_axi_ref_rvalid;
    logic               s_axi_ref_arready;
    logic [5:0]         m_axi_ref_raddr;
    logic [5:0]         m_axi_ref_rlen;
    logic               m_axi_ref_rready;
    logic               s_axi_ref_rvalid;
    logic signed [11:0] ref_i;
    logic signed [11:0] ref_q;
    logic               s_axi_ref_rlast;
    logic               loaded;

    int errors = 0;
    int checks = 0;
    int accept_cnt = 0;
    logic [24:0] exp_q[$];
    logic signed [11:0] m_i [8];
    logic signed [11:0] m_q [8];
    int m_wptr = 0;
    logic stall_prev = 1'b0;

    ref_circular_buffer #(
        .I_BITS     (12),
        .Q_BITS     (12),
        .BUF_LENGTH (8),
        .INDEX_BITS (6)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axi_wr_valid    (s_axi_wr_valid),
        .s_axi_wr_ready    (s_axi_wr_ready),
        .wr_i              (wr_i),
        .wr_q              (wr_q),
        .wr_last           (wr_last),
        .m_axi_ref_rvalid  (m_axi_ref_rvalid),
        .s_axi_ref_arready (s_axi_ref_arready),
        .m_axi_ref_raddr   (m_axi_ref_raddr),
        .m_axi_ref_rlen    (m_axi_ref_rlen),
        .m_axi_ref_rready  (m_axi_ref_rready),
        .s_axi_ref_rvalid  (s_axi_ref_rvalid),
        .ref_i             (ref_i),
        .ref_q             (ref_q),
        .s_axi_ref_rlast   (s_axi_ref_rlast),
        .loaded            (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] pk(input int idx, input logic last);
        return {m_i[idx], m_q[idx], last};
    endfunction

    task automatic write_sample(input int iv, input int qv, input logic last);
        int c;
        s_axi_wr_valid = 1'b1;
        wr_i = 12'(iv);
        wr_q = 12'(qv);
        wr_last = last;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s_axi_wr_ready) break;
        end
        chk("wr_ready_seen", 32'(s_axi_wr_ready), 32'(1));
        tick();
        s_axi_wr_valid = 1'b0;
        wr_last = 1'b0;
        m_i[m_wptr] = 12'(iv);
        m_q[m_wptr] = 12'(qv);
        m_wptr = (last || m_wptr == 7) ? 0 : m_wptr + 1;
    endtask

    task automatic request(input int ra, input int rl);
        int c;
        int start;
        m_axi_ref_raddr = 6'(ra);
        m_axi_ref_rlen = 6'(rl);
        m_axi_ref_rvalid = 1'b1;
        for (c = 0; c < 60; c++) begin
            @(negedge clk);
            if (s_axi_ref_arready) break;
        end
        chk("arready_seen", 32'(s_axi_ref_arready), 32'(1));
        start = (ra >= 8) ? ra - 8 : ra;
        for (int k = 0; k <= rl; k++) begin
            exp_q.push_back(pk((start + k) % 8, k == rl));
        end
        tick();
        m_axi_ref_rvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("drain", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    // Output monitor: compares the presented sample with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && s_axi_ref_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 32'(s_axi_ref_rvalid), 32'(0));
            end else begin
                chk("sample", 32'({ref_i, ref_q, s_axi_ref_rlast}), 32'(exp_q[0]));
                if (m_axi_ref_rready) begin
                    void'(exp_q.pop_front());
                    accept_cnt++;
                end
            end
        end
        if (rst_n && stall_prev) begin
            chk("hold_rvalid", 32'(s_axi_ref_rvalid), 32'(1));
        end
        stall_prev = rst_n && s_axi_ref_rvalid && !m_axi_ref_rready;
    end

    initial begin
        int a0;
        logic [3:0] pat;
        pat = 4'b1001;
        rst_n = 1'b0;
        s_axi_wr_valid = 1'b0;
        wr_i = 12'sd0;
        wr_q = 12'sd0;
        wr_last = 1'b0;
        m_axi_ref_rvalid = 1'b0;
        m_axi_ref_raddr = 6'd0;
        m_axi_ref_rlen = 6'd0;
        m_axi_ref_rready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            m_i[k] = 12'sd0;
            m_q[k] = 12'sd0;
        end
        #23;
        chk("rst_outputs", 32'({s_axi_wr_ready, s_axi_ref_arready, s_axi_ref_rvalid,
                                s_axi_ref_rlast, loaded, ref_i, ref_q}), 32'(0));
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_wr_ready", 32'(s_axi_wr_ready), 32'(1));
        chk("idle_arready", 32'(s_axi_ref_arready), 32'(0));

        // 1: load k, -k and read all eight samples
        for (int k = 0; k < 7; k++) write_sample(k, -k, 1'b0);
        chk("loaded_before_last", 32'(loaded), 32'(0));
        write_sample(7, -7, 1'b1);
        chk("loaded_after_last", 32'(loaded), 32'(1));
        chk("arready_after_load", 32'(s_axi_ref_arready), 32'(1));
        request(0, 7);
        chk("lat_edge0", 32'(s_axi_ref_rvalid), 32'(0));
        tick();
        chk("lat_edge1", 32'(s_axi_ref_rvalid), 32'(0));
        tick();
        chk("lat_edge2", 32'(s_axi_ref_rvalid), 32'(1));
        wait_idle(40);

        // 2: wrapping burst
        request(6, 4);
        wait_idle(40);
        tick();
        chk("arready_after_burst", 32'(s_axi_ref_arready), 32'(1));

        // 3: out-of-range start, single sample
        request(10, 0);
        wait_idle(40);

        // 4: backpressure pattern 1,0,0,1
        a0 = accept_cnt;
        request(3, 7);
        for (int c = 0; c < 80; c++) begin
            m_axi_ref_rready = pat[c % 4];
            tick();
            if (exp_q.size() == 0) break;
        end
        m_axi_ref_rready = 1'b1;
        wait_idle(40);
        chk("accept_count", 32'(accept_cnt - a0), 32'(8));

        // 5: write stalled during a burst, taken right after it
        request(0, 7);
        s_axi_wr_valid = 1'b1;
        wr_i = 12'sd100;
        wr_q = -12'sd100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("wr_stalled", 32'(s_axi_wr_ready), 32'(0));
        end
        @(negedge clk);
        chk("wr_released", 32'(s_axi_wr_ready), 32'(1));
        tick();
        s_axi_wr_valid = 1'b0;
        m_i[m_wptr] = 12'sd100;
        m_q[m_wptr] = -12'sd100;
        m_wptr = m_wptr + 1;
        wait_idle(40);
        request(0, 0);
        wait_idle(40);

        // same-cycle write and request: the burst sees the new sample
        s_axi_wr_valid = 1'b1;
        wr_i = 12'sd200;
        wr_q = -12'sd200;
        m_axi_ref_raddr = 6'(m_wptr);
        m_axi_ref_rlen = 6'd0;
        m_axi_ref_rvalid = 1'b1;
        @(negedge clk);
        chk("wf_ready", 32'({s_axi_wr_ready, s_axi_ref_arready}), 32'(3));
        m_i[m_wptr] = 12'sd200;
        m_q[m_wptr] = -12'sd200;
        exp_q.push_back(pk(m_wptr, 1'b1));
        m_wptr = m_wptr + 1;
        tick();
        s_axi_wr_valid = 1'b0;
        m_axi_ref_rvalid = 1'b0;
        wait_idle(40);

        // 6: reset mid-burst
        request(0, 7);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({s_axi_wr_ready, s_axi_ref_arready, s_axi_ref_rvalid,
                                    s_axi_ref_rlast, loaded, ref_i, ref_q}), 32'(0));
        exp_q.delete();
        m_wptr = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("post_rst_quiet", 32'({s_axi_ref_rvalid, s_axi_ref_arready, loaded}), 32'(0));
        end
        for (int k = 0; k < 7; k++) write_sample(30 + k, -(30 + k), 1'b0);
        chk("reload_arready_low", 32'(s_axi_ref_arready), 32'(0));
        write_sample(37, -37, 1'b1);
        chk("reload_arready_high", 32'(s_axi_ref_arready), 32'(1));
        request(5, 10);
        wait_idle(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
